// File: rtl/pc_update_pkg.sv
// Shared types and constants for the PC update path: trap sequencer states,
// latched trap cause codes and the conventional next-PC source slots.
package pc_update_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_EXT      = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

   // Slot assignment of the candidates on src_data, as wired by the datapath
   localparam int SRC_PC4     = 0;
   localparam int SRC_ALUOUT  = 1;
   localparam int SRC_JUMP    = 2;
   localparam int SRC_EPC     = 3;
   localparam int SRC_SIGNEXT = 4;
   localparam int SRC_MEM     = 5;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational next-PC selector; valid drops when sel names no existing
// candidate so the caller can refuse the load instead of jumping to garbage.
module pc_src_mux #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 6,
   localparam int SEL_W  = $clog2(NUM_SRC)
) (
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   output logic [WIDTH-1:0]         next_pc,
   output logic                     valid
);

   always_comb begin
      next_pc = '0;
      valid   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            next_pc = src_data[i*WIDTH +: WIDTH];
            valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_update_unit.sv
// PC and EPC registers with conditional load, selector and alignment checks,
// and a one-cycle trap sequencer that redirects the PC to exc_vector.
module pc_update_unit
   import pc_update_pkg::*;
#(
   parameter int              WIDTH       = 32,
   parameter int              NUM_SRC     = 6,
   localparam int             SEL_W       = $clog2(NUM_SRC),
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter int              ALIGN_CHECK = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic                     pc_write,
   input  logic                     pc_write_cond,
   input  logic                     cond,
   input  logic                     exc_req,
   input  logic [WIDTH-1:0]         exc_vector,
   output logic [WIDTH-1:0]         pc_out,
   output logic [WIDTH-1:0]         epc_out,
   output logic                     busy,
   output logic                     exc_ack,
   output logic [1:0]               cause,
   output logic                     sel_err
);

   state_t            state;
   logic [WIDTH-1:0]  next_pc;
   logic              next_valid;
   logic              load;
   logic              misaligned;

   pc_src_mux #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC)
   ) u_mux (
      .sel      (sel),
      .src_data (src_data),
      .next_pc  (next_pc),
      .valid    (next_valid)
   );

   assign load       = pc_write | (pc_write_cond & cond);
   assign misaligned = (ALIGN_CHECK != 0) && (next_pc[1:0] != 2'b00);
   assign busy       = (state == TRAP);

   // External requests outrank loads; a bad selector only flags, a bad
   // target traps with EPC pointing at the instruction that asked for it.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out  <= RESET_PC;
         epc_out <= '0;
         cause   <= CAUSE_NONE;
         state   <= RUN;
         exc_ack <= 1'b0;
         sel_err <= 1'b0;
      end else begin
         exc_ack <= 1'b0;
         sel_err <= 1'b0;
         case (state)
            RUN: begin
               if (exc_req) begin
                  epc_out <= pc_out;
                  cause   <= CAUSE_EXT;
                  state   <= TRAP;
               end else if (load && !next_valid) begin
                  sel_err <= 1'b1;
               end else if (load && misaligned) begin
                  epc_out <= pc_out;
                  cause   <= CAUSE_MISALIGN;
                  state   <= TRAP;
               end else if (load) begin
                  pc_out <= next_pc;
               end
            end
            TRAP: begin
               pc_out  <= exc_vector;
               exc_ack <= 1'b1;
               state   <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed, table-driven bench for pc_update_unit: one record per clock of
// stimulus with hand-computed register outputs expected after that edge.
module tb_pc_update_unit;
   import pc_update_pkg::*;

   localparam int WIDTH   = 32;
   localparam int NUM_SRC = 6;
   localparam int SEL_W   = $clog2(NUM_SRC);

   logic                     clk = 1'b0;
   logic                     reset;
   logic [SEL_W-1:0]         sel;
   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic                     pc_write;
   logic                     pc_write_cond;
   logic                     cond;
   logic                     exc_req;
   logic [WIDTH-1:0]         exc_vector;
   logic [WIDTH-1:0]         pc_out;
   logic [WIDTH-1:0]         epc_out;
   logic                     busy;
   logic                     exc_ack;
   logic [1:0]               cause;
   logic                     sel_err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic             rst;
      logic [SEL_W-1:0] sel;
      logic [31:0]      tgt;
      logic             pw;
      logic             pwc;
      logic             cnd;
      logic             exc;
      logic [31:0]      vec;
      logic [31:0]      e_pc;
      logic [31:0]      e_epc;
      logic             e_busy;
      logic             e_ack;
      logic [1:0]       e_cause;
      logic             e_serr;
   } vec_t;

   vec_t vecs[$];

   pc_update_unit #(
      .WIDTH       (WIDTH),
      .NUM_SRC     (NUM_SRC),
      .RESET_PC    (32'h0),
      .ALIGN_CHECK (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sel           (sel),
      .src_data      (src_data),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .cond          (cond),
      .exc_req       (exc_req),
      .exc_vector    (exc_vector),
      .pc_out        (pc_out),
      .epc_out       (epc_out),
      .busy          (busy),
      .exc_ack       (exc_ack),
      .cause         (cause),
      .sel_err       (sel_err)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic [SEL_W-1:0] s, input logic [31:0] tgt,
                      input logic pw, input logic pwc, input logic cnd, input logic exc,
                      input logic [31:0] vec, input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_busy, input logic e_ack, input logic [1:0] e_cause,
                      input logic e_serr);
      vec_t v;
      v.rst = rst; v.sel = s; v.tgt = tgt; v.pw = pw; v.pwc = pwc; v.cnd = cnd;
      v.exc = exc; v.vec = vec; v.e_pc = e_pc; v.e_epc = e_epc; v.e_busy = e_busy;
      v.e_ack = e_ack; v.e_cause = e_cause; v.e_serr = e_serr;
      vecs.push_back(v);
   endtask

   // Unselected slots carry distinct aligned values so a wrong index shows up
   task automatic apply_stimulus(input vec_t v);
      @(negedge clk);
      reset = v.rst;
      for (int i = 0; i < NUM_SRC; i++)
         src_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i) * 32'h10;
      if (int'(v.sel) < NUM_SRC)
         src_data[int'(v.sel)*WIDTH +: WIDTH] = v.tgt;
      sel           = v.sel;
      pc_write      = v.pw;
      pc_write_cond = v.pwc;
      cond          = v.cnd;
      exc_req       = v.exc;
      exc_vector    = v.vec;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input int idx, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input vec_t v);
      check_output(idx, "pc_out",  pc_out,          v.e_pc);
      check_output(idx, "epc_out", epc_out,         v.e_epc);
      check_output(idx, "busy",    32'(busy),       32'(v.e_busy));
      check_output(idx, "exc_ack", 32'(exc_ack),    32'(v.e_ack));
      check_output(idx, "cause",   32'(cause),      32'(v.e_cause));
      check_output(idx, "sel_err", 32'(sel_err),    32'(v.e_serr));
   endtask

   initial begin
      reset = 1'b1; sel = '0; src_data = '0; pc_write = 1'b0;
      pc_write_cond = 1'b0; cond = 1'b0; exc_req = 1'b0; exc_vector = '0;

      //  rst sel tgt           pw pwc c  exc vec           pc            epc           bsy ack cause           serr
      add(1, 0, 32'h0,         0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 0, CAUSE_NONE,     0);
      add(1, 0, 32'h0,         0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 0, CAUSE_NONE,     0);
      add(0, SEL_W'(SRC_ALUOUT), 32'h40, 1, 0, 0, 0, 32'h0, 32'h40, 32'h0, 0, 0, CAUSE_NONE, 0);
      add(0, SEL_W'(SRC_JUMP), 32'h100, 0, 1, 0, 0, 32'h0,  32'h40,  32'h0,   0, 0, CAUSE_NONE,     0);
      add(0, SEL_W'(SRC_JUMP), 32'h100, 0, 1, 1, 0, 32'h0,  32'h100, 32'h0,   0, 0, CAUSE_NONE,     0);
      add(0, 7, 32'h0,         1, 0, 0, 0, 32'h0,   32'h100, 32'h0,   0, 0, CAUSE_NONE,     1);
      add(0, 0, 32'h0,         0, 0, 0, 0, 32'h0,   32'h100, 32'h0,   0, 0, CAUSE_NONE,     0);
      add(0, 6, 32'h0,         1, 0, 0, 0, 32'h0,   32'h100, 32'h0,   0, 0, CAUSE_NONE,     1);
      // Misaligned target traps, then the vector loads while inputs are ignored
      add(0, SEL_W'(SRC_ALUOUT), 32'h42, 1, 0, 0, 0, 32'hFF, 32'h100, 32'h100, 1, 0, CAUSE_MISALIGN, 0);
      add(0, SEL_W'(SRC_PC4), 32'h8, 1, 0, 0, 1, 32'hFF, 32'hFF,  32'h100, 0, 1, CAUSE_MISALIGN, 0);
      add(0, 0, 32'h0,         0, 0, 0, 0, 32'hFF,  32'hFF,  32'h100, 0, 0, CAUSE_MISALIGN, 0);
      add(0, SEL_W'(SRC_EPC), 32'h200, 1, 0, 0, 0, 32'h0,  32'h200, 32'h100, 0, 0, CAUSE_MISALIGN, 0);
      // External request beats a simultaneous load; held request re-traps later
      add(0, SEL_W'(SRC_PC4), 32'h204, 1, 0, 0, 1, 32'h300, 32'h200, 32'h200, 1, 0, CAUSE_EXT, 0);
      add(0, 0, 32'h0,         0, 0, 0, 1, 32'h300, 32'h300, 32'h200, 0, 1, CAUSE_EXT,      0);
      add(0, 0, 32'h0,         0, 0, 0, 1, 32'h310, 32'h300, 32'h300, 1, 0, CAUSE_EXT,      0);
      add(0, 0, 32'h0,         0, 0, 0, 0, 32'h310, 32'h310, 32'h300, 0, 1, CAUSE_EXT,      0);
      // Untaken branch is not a load: no selector or alignment check
      add(0, 7, 32'h0,         0, 1, 0, 0, 32'h0,   32'h310, 32'h300, 0, 0, CAUSE_EXT,      0);
      add(0, SEL_W'(SRC_PC4), 32'h3, 0, 1, 0, 0, 32'h0,   32'h310, 32'h300, 0, 0, CAUSE_EXT,      0);
      add(0, SEL_W'(SRC_MEM), 32'h44, 0, 1, 1, 0, 32'h0,  32'h44,  32'h300, 0, 0, CAUSE_EXT,      0);
      add(0, SEL_W'(SRC_SIGNEXT), 32'h48, 1, 0, 0, 0, 32'h0, 32'h48, 32'h300, 0, 0, CAUSE_EXT,   0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         check_all(i, vecs[i]);
      end

      // Reset landing on the TRAP cycle must cancel the vector load and ack
      vecs.delete();
      add(0, SEL_W'(SRC_ALUOUT), 32'h41, 1, 0, 0, 0, 32'hFE, 32'h48, 32'h48, 1, 0, CAUSE_MISALIGN, 0);
      add(1, 0, 32'h0,         0, 0, 0, 0, 32'hFE,  32'h0,   32'h0,   0, 0, CAUSE_NONE,     0);
      add(0, 0, 32'h0,         0, 0, 0, 0, 32'hFE,  32'h0,   32'h0,   0, 0, CAUSE_NONE,     0);
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         check_all(100 + i, vecs[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
